tone_sample_generator: RTL and testbench

//  Synthesises signed 20-bit PCM tone samples at a fixed audio sample rate from a phase accumulator and

---
 rtl/tone_sample_generator.sv | 140 ++++++++++++++
 tb/tb_tone_sample_generator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tone_sample_generator.sv
// Phase-accumulator tone synthesiser feeding signed 20-bit PCM samples into the AC97 sample FIFO.
// Optional macro TONE_GEN_DROP_COUNT_EN adds a saturating drop_count output for overwritten samples.
module tone_sample_generator #(
  parameter int unsigned SYS_CLK_FREQ = 50_000_000,
  parameter int unsigned SAMPLE_RATE  = 48_000,
  parameter logic [19:0] AMPLITUDE    = 20'h3FFFF
) (
  input  logic        system_clock,
  input  logic        system_reset,
  input  logic        tone_enable,
  input  logic [23:0] tone_freq_word,
  input  logic [1:0]  wave_sel,
  input  logic [3:0]  atten,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [19:0] fifo_din
`ifdef TONE_GEN_DROP_COUNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int unsigned DIV      = SYS_CLK_FREQ / SAMPLE_RATE;
  localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PHASE_W  = 24;
  localparam int unsigned SAMPLE_W = 20;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_FULL} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     div_cnt;
  logic [PHASE_W-1:0]   phase;
  logic                 tick_c;
  logic                 load_c;
  logic                 wr_en_d;
  logic [SAMPLE_W-1:0]  raw_c;
  logic [SAMPLE_W-1:0]  tri_c;
  logic [SAMPLE_W-1:0]  sample_c;

  // Sample-rate divider: one tick every DIV clocks
  assign tick_c = (div_cnt == DIV_LAST);

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      phase <= '0;
    end else if (tick_c) begin
      phase <= tone_enable ? (phase + tone_freq_word) : '0;
    end
  end

  // Waveform lookup from the current phase, then sign-preserving attenuation
  assign tri_c = phase[22:3] ^ {SAMPLE_W{phase[23]}};

  always_comb begin
    raw_c = '0;
    case (wave_sel)
      2'b00:   raw_c = phase[23] ? (~AMPLITUDE + SAMPLE_W'(1)) : AMPLITUDE;
      2'b01:   raw_c = {~phase[23], phase[22:4]};
      2'b10:   raw_c = tri_c ^ 20'h80000;
      default: raw_c = '0;
    endcase
    if (!tone_enable) begin
      raw_c = '0;
    end
  end

  assign sample_c = SAMPLE_W'($signed(raw_c) >>> atten);

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A tick always wins: the held sample is replaced and the write restarts with the newest one
  always_comb begin
    state_d = state_q;
    wr_en_d = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_c) begin
          load_c  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE, WAIT_FULL: begin
        if (tick_c) begin
          load_c  = 1'b1;
          state_d = WRITE;
        end else if (!fifo_full) begin
          wr_en_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_FULL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      fifo_wr_en <= wr_en_d;
      if (load_c) begin
        fifo_din <= sample_c;
      end
    end
  end

`ifdef TONE_GEN_DROP_COUNT_EN
  logic drop_c;
  assign drop_c = tick_c && (state_q != IDLE);

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      drop_count <= '0;
    end else if (drop_c && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tone_sample_generator.sv
// Scoreboard bench for tone_sample_generator (DIV=10); drop_count checks when TONE_GEN_DROP_COUNT_EN is defined.
module tb_tone_sample_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tone_enable = 1'b0;
  logic [23:0] tone_freq_word = '0;
  logic [1:0]  wave_sel = '0;
  logic [3:0]  atten = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [19:0] fifo_din;
`ifdef TONE_GEN_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  typedef struct {
    logic [19:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc;
  int          total = 0;
  int          bad = 0;

  tone_sample_generator #(
    .SYS_CLK_FREQ(480),
    .SAMPLE_RATE (48),
    .AMPLITUDE   (20'h3FFFF)
  ) dut (
    .system_clock  (clk),
    .system_reset  (rst),
    .tone_enable   (tone_enable),
    .tone_freq_word(tone_freq_word),
    .wave_sel      (wave_sel),
    .atten         (atten),
    .fifo_full     (fifo_full),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din)
`ifdef TONE_GEN_DROP_COUNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Posedges since reset release; div_cnt in the DUT equals cyc mod 10
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe pops one expected sample and its expected cycle
  always @(negedge clk) begin
    if (!rst && fifo_wr_en) begin
      check("wr_en_while_full", 32'(fifo_full), 32'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got din=%h at cyc=%0d want no write", fifo_din, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sample", 32'(fifo_din), 32'(e.data));
        check("write_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_mod(input int unsigned m);
    do @(negedge clk); while ((cyc % 10) != m);
  endtask

  // Drive config ahead of the next tick (at cyc%10==9); the write lands 6 clocks later
  task automatic issue(input logic en, input logic [23:0] word, input logic [1:0] wave,
                       input logic [3:0] att, input logic [19:0] exp, input bit push);
    exp_t e;
    wait_mod(5);
    tone_enable    = en;
    tone_freq_word = word;
    wave_sel       = wave;
    atten          = att;
    if (push) begin
      e.data = exp;
      e.cyc  = cyc + 6;
      q.push_back(e);
    end
  endtask

  logic [19:0] tri_tab [8];
  int unsigned t0;

  initial begin
    tri_tab = '{20'h80000, 20'hC0000, 20'h00000, 20'h40000,
                20'h7FFFF, 20'h3FFFF, 20'hFFFFF, 20'hBFFFF};
    #23;
    check("reset_wr_en", 32'(fifo_wr_en), 32'd0);
    check("reset_din", 32'(fifo_din), 32'd0);
`ifdef TONE_GEN_DROP_COUNT_EN
    check("reset_drop_count", 32'(drop_count), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 3; k++) issue(1'b0, 24'h100000, 2'b00, 4'd0, 20'h00000, 1'b1);

    for (int k = 0; k < 18; k++)
      issue(1'b1, 24'h100000, 2'b00, 4'd0, ((k % 16) < 8) ? 20'h3FFFF : 20'hC0001, 1'b1);

    issue(1'b0, 24'h080000, 2'b01, 4'd2, 20'h00000, 1'b1);
    for (int k = 0; k < 18; k++)
      issue(1'b1, 24'h080000, 2'b01, 4'd2, 20'(32'hE0000 + 32'(k) * 32'h2000), 1'b1);

    issue(1'b0, 24'h080000, 2'b01, 4'd15, 20'h00000, 1'b1);
    for (int k = 0; k < 20; k++)
      issue(1'b1, 24'h080000, 2'b01, 4'd15, 20'(k - 16), 1'b1);

    issue(1'b0, 24'h200000, 2'b10, 4'd0, 20'h00000, 1'b1);
    for (int k = 0; k < 10; k++)
      issue(1'b1, 24'h200000, 2'b10, 4'd0, tri_tab[k % 8], 1'b1);

    for (int k = 0; k < 2; k++) issue(1'b1, 24'h100000, 2'b11, 4'd0, 20'h00000, 1'b1);

    issue(1'b0, 24'h000000, 2'b00, 4'd0, 20'h00000, 1'b1);
    for (int k = 0; k < 3; k++) issue(1'b1, 24'h000000, 2'b00, 4'd0, 20'h3FFFF, 1'b1);

    // FIFO full across two ticks: only the newest sample (atten=2) is written on release
    issue(1'b0, 24'h100000, 2'b00, 4'd0, 20'h00000, 1'b1);
    issue(1'b1, 24'h100000, 2'b00, 4'd0, 20'h00000, 1'b0);
    wait_mod(9);
    fifo_full = 1'b1;
    t0 = cyc;
    issue(1'b1, 24'h100000, 2'b00, 4'd1, 20'h00000, 1'b0);
    issue(1'b1, 24'h100000, 2'b00, 4'd2, 20'h00000, 1'b0);
    while (cyc != t0 + 25) @(negedge clk);
    fifo_full = 1'b0;
    begin
      exp_t e;
      e.data = 20'h0FFFF;
      e.cyc  = t0 + 26;
      q.push_back(e);
    end
`ifdef TONE_GEN_DROP_COUNT_EN
    check("drop_count_after_full", 32'(drop_count), 32'd2);
`endif
    issue(1'b1, 24'h100000, 2'b00, 4'd0, 20'h3FFFF, 1'b1);

    // Reset while waiting on a full FIFO, then restart from phase 0
    issue(1'b0, 24'h800000, 2'b00, 4'd0, 20'h00000, 1'b1);
    issue(1'b1, 24'h800000, 2'b00, 4'd0, 20'h00000, 1'b0);
    wait_mod(9);
    fifo_full = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_wr_en", 32'(fifo_wr_en), 32'd0);
    check("midreset_din", 32'(fifo_din), 32'd0);
`ifdef TONE_GEN_DROP_COUNT_EN
    check("midreset_drop_count", 32'(drop_count), 32'd0);
`endif
    check("midreset_queue_empty", 32'(q.size()), 32'd0);
    @(negedge clk);
    fifo_full = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(1'b1, 24'h800000, 2'b00, 4'd0, 20'h3FFFF, 1'b1);
    issue(1'b1, 24'h800000, 2'b00, 4'd0, 20'hC0001, 1'b1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
